// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM encoding, access size codes, funct3 constants.
package lsu_pkg;

    localparam int LSU_WIDTH  = 64;
    localparam int LSU_STRB_W = LSU_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Access size in bytes (1, 2, 4 or 8) from funct3[1:0].
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shifts the addressed bytes down from the raw doubleword and extends.
module load_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = LSU_WIDTH
) (
    input  logic [2:0]       off_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shifted;
    logic             sx;

    // Bytes past the doubleword end shift in as zero, before extension.
    assign shifted = rdata_i >> {off_i, 3'b000};
    assign sx      = ~funct3_i[2];

    always_comb begin
        data_o = shifted;
        case (funct3_i[1:0])
            SZ_B:    data_o = {{(WIDTH-8){sx & shifted[7]}},   shifted[7:0]};
            SZ_H:    data_o = {{(WIDTH-16){sx & shifted[15]}}, shifted[15:0]};
            SZ_W:    data_o = {{(WIDTH-32){sx & shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 memory-access stage: one load/store per handshake, strobes/shifts stores, aligns loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and report rsp_misalign.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH  = LSU_WIDTH,
    parameter int STRB_W = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              rsp_misalign,
`endif
    output logic [WIDTH-1:0]  rsp_rdata
);

    lsu_state_e       state_q, state_d;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] ld_data;
    logic             accept;
    logic             mis_now;

    logic [3:0]          nbytes;
    logic [2*STRB_W-1:0] strb_wide;

    assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic       misalign_q;
    logic [3:0] req_nbytes;
    assign req_nbytes = size_bytes(req_funct3[1:0]);
    assign mis_now    = (req_addr[2:0] & (req_nbytes[2:0] - 3'd1)) != 3'd0;
    assign rsp_misalign = misalign_q;
`else
    assign mis_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)     state_d = mis_now ? ST_DONE : ST_REQ;
            ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid) state_d = ST_DONE;
            ST_DONE: if (rsp_ready)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
            end
            if (state_q == ST_WAIT && mem_rsp_valid)
                rdata_q <= is_store_q ? '0 : ld_data;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (accept)
            misalign_q <= mis_now;
        else if (state_q == ST_DONE && rsp_ready)
            misalign_q <= 1'b0;
    end
`endif

    load_align #(.WIDTH(WIDTH)) u_load_align (
        .off_i    (addr_q[2:0]),
        .funct3_i (funct3_q),
        .rdata_i  (mem_rdata),
        .data_o   (ld_data)
    );

    // Strobes are built double-width so lanes past byte 7 fall off on truncation.
    assign nbytes    = size_bytes(funct3_q[1:0]);
    assign strb_wide = (2*STRB_W)'((1 << nbytes) - 1) << addr_q[2:0];

    assign req_ready     = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_we        = (state_q == ST_REQ) && is_store_q;
    assign mem_addr      = {addr_q[WIDTH-1:3], 3'b000};
    assign mem_wdata     = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_wstrb     = mem_we ? strb_wide[STRB_W-1:0] : '0;
    assign rsp_valid     = (state_q == ST_DONE);
    assign rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; builds with or without LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        rsp_misalign;
`endif

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
`ifdef LSU_MISALIGN_TRAP_EN
        .rsp_misalign  (rsp_misalign),
`endif
        .rsp_rdata     (rsp_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full handshake with hand-computed expectations; stalls checked cycle by cycle.
    task automatic txn(input string nm, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int req_dly, input int rsp_dly,
                       input logic [63:0] e_addr, input logic [63:0] e_wdata,
                       input logic [7:0] e_strb, input logic [63:0] e_rdata);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        step();
        req_valid = 1'b0; req_wdata = '0; req_addr = '0;
        chk({nm, ".req_ready"}, 64'(req_ready), 64'd0);
        for (int i = 0; i <= req_dly; i++) begin
            chk({nm, ".mem_req_valid"}, 64'(mem_req_valid), 64'd1);
            chk({nm, ".mem_we"},        64'(mem_we), 64'(st));
            chk({nm, ".mem_addr"},      mem_addr, e_addr);
            chk({nm, ".mem_wstrb"},     64'(mem_wstrb), 64'(e_strb));
            if (st) chk({nm, ".mem_wdata"}, mem_wdata, e_wdata);
            if (i == req_dly) mem_req_ready = 1'b1;
            step();
        end
        mem_req_ready = 1'b0;
        chk({nm, ".wait_no_req"}, 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rdata = rd;
        step();
        mem_rsp_valid = 1'b0; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int i = 0; i <= rsp_dly; i++) begin
            chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, ".rsp_rdata"}, rsp_rdata, e_rdata);
            chk({nm, ".busy"},      64'(req_ready), 64'd0);
            // A request presented during DONE must not be taken.
            req_valid = 1'b1;
            if (i == rsp_dly) rsp_ready = 1'b1;
            step();
        end
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk({nm, ".exit_rsp"},   64'(rsp_valid), 64'd0);
        chk({nm, ".exit_ready"}, 64'(req_ready), 64'd1);
        chk({nm, ".exit_noreq"}, 64'(mem_req_valid), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst.req_ready", 64'(req_ready), 64'd1);
        chk("rst.mem_req",   64'(mem_req_valid), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.mem_addr",  mem_addr, 64'd0);
        chk("rst.mem_wdata", mem_wdata, 64'd0);
        chk("rst.rsp_rdata", rsp_rdata, 64'd0);
        rst_n = 1'b1;
        step();

        txn("lb", 1'b0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0,
            64'h1000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
        txn("lhu", 1'b0, 3'b101, 64'h1006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0,
            64'h1000, 64'h0, 8'h00, 64'h0000_0000_0000_BEEF);
        txn("sw", 1'b1, 3'b010, 64'h2004, 64'h1234_5678, 64'h0, 4, 3,
            64'h2000, 64'h1234_5678_0000_0000, 8'hF0, 64'h0);
        txn("lw", 1'b0, 3'b010, 64'h0004, 64'h0, 64'h8000_0001_0000_0000, 1, 1,
            64'h0000, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0001);
        txn("lbu", 1'b0, 3'b100, 64'h0010, 64'h0, 64'h0000_0000_0000_00FF, 0, 0,
            64'h0010, 64'h0, 8'h00, 64'h0000_0000_0000_00FF);
        txn("ld7", 1'b0, 3'b111, 64'h0018, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 0,
            64'h0018, 64'h0, 8'h00, 64'h8123_4567_89AB_CDEF);
        txn("sd", 1'b1, 3'b011, 64'h0008, 64'h1122_3344_5566_7788, 64'h0, 0, 0,
            64'h0008, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
        txn("sb", 1'b1, 3'b100, 64'h0045, 64'h0000_0000_0000_00A5, 64'h0, 0, 0,
            64'h0040, 64'h0000_A500_0000_0000, 8'h20, 64'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h3004;
        step();
        req_valid = 1'b0;
        chk("mis.mem_req",   64'(mem_req_valid), 64'd0);
        chk("mis.rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mis.flag",      64'(rsp_misalign), 64'd1);
        chk("mis.rdata",     rsp_rdata, 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("mis.clear",     64'(rsp_misalign), 64'd0);
        chk("mis.idle",      64'(req_ready), 64'd1);
`else
        txn("ld_cross", 1'b0, 3'b011, 64'h3004, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0,
            64'h3000, 64'h0, 8'h00, 64'h0000_0000_AAAA_BBBB);
        txn("sh_cross", 1'b1, 3'b001, 64'h0007, 64'h0000_0000_0000_ABCD, 64'h0, 0, 0,
            64'h0000, 64'hCD00_0000_0000_0000, 8'h80, 64'h0);
`endif

        // Reset while waiting for the memory response.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h5000;
        mem_req_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        chk("rw.in_wait", 64'(mem_req_valid | req_ready | rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rw.req_ready", 64'(req_ready), 64'd1);
        chk("rw.rsp_valid", 64'(rsp_valid), 64'd0);
        #1;
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'h1234;
        step();
        mem_rsp_valid = 1'b0;
        chk("rw.late_rsp", 64'(rsp_valid), 64'd0);
        chk("rw.idle",     64'(req_ready), 64'd1);
        chk("rw.rdata",    rsp_rdata, 64'd0);
        step();
        chk("rw.still",    64'(rsp_valid | mem_req_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
